// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the instruction/data memory port arbiter.
package mem_arb_pkg;

   // Which requester owns the response that arrives in the current cycle.
   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_I    = 2'd1,
      OWN_D    = 2'd2
   } owner_t;

   // Default bound on consecutive data grants while fetch waits.
   localparam int unsigned MAX_D_RUN_DEF = 4;

   // Counter width needed to hold 0..max_run inclusive.
   function automatic int unsigned run_cnt_width(input int unsigned max_run);
      return $clog2(max_run + 1);
   endfunction

endpackage

// File: rtl/arb_fair_cnt.sv
// Saturating count of data grants taken while fetch was left waiting.
module arb_fair_cnt #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   input  logic             clr_i,
   input  logic [CNT_W-1:0] limit_i,
   output logic             at_limit_o
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Clear wins over increment; increment stops once the limit is reached.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q < limit_i)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Counter register with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign at_limit_o = (cnt_q >= limit_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port memory between fetch and data ports, one access
// per cycle, and tags the next-cycle read response with its owner.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned MAX_D_RUN  = MAX_D_RUN_DEF
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   // fetch port
   input  logic                  i_req_i,
   input  logic [ADDR_WIDTH-1:0] i_addr_i,
   output logic                  i_gnt_o,
   output logic                  i_valid_o,
   output logic [DATA_WIDTH-1:0] i_rdata_o,
   // data port
   input  logic                  d_req_i,
   input  logic                  d_we_i,
   input  logic [ADDR_WIDTH-1:0] d_addr_i,
   input  logic [DATA_WIDTH-1:0] d_wdata_i,
   output logic                  d_gnt_o,
   output logic                  d_valid_o,
   output logic [DATA_WIDTH-1:0] d_rdata_o,
   // memory
   output logic                  mem_en_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int unsigned      CNT_W     = run_cnt_width(MAX_D_RUN);
   localparam logic [CNT_W-1:0] RUN_LIMIT = CNT_W'(MAX_D_RUN);

   logic   at_limit;
   logic   cnt_inc;
   logic   cnt_clr;
   owner_t owner_q;
   owner_t owner_d;

   // Grant: data wins a tie until fetch has waited MAX_D_RUN data grants.
   always_comb begin
      i_gnt_o = 1'b0;
      d_gnt_o = 1'b0;
      if (!rst_i) begin
         if (d_req_i && (!i_req_i || !at_limit)) begin
            d_gnt_o = 1'b1;
         end else if (i_req_i) begin
            i_gnt_o = 1'b1;
         end
      end
   end

   // Count data grants only while fetch is waiting; any fetch grant or idle
   // fetch port restarts the run.
   assign cnt_inc = d_gnt_o & i_req_i;
   assign cnt_clr = i_gnt_o | ~i_req_i;

   arb_fair_cnt #(
      .CNT_W (CNT_W)
   ) u_fair_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .inc_i      (cnt_inc),
      .clr_i      (cnt_clr),
      .limit_i    (RUN_LIMIT),
      .at_limit_o (at_limit)
   );

   // Memory command mux; idle bus is driven to zero, fetch never writes.
   always_comb begin
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      if (d_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_we_o    = d_we_i;
         mem_addr_o  = d_addr_i;
         mem_wdata_o = d_wdata_i;
      end else if (i_gnt_o) begin
         mem_en_o    = 1'b1;
         mem_addr_o  = i_addr_i;
      end
   end

   // Response owner register; reset drops any in-flight response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_q <= OWN_NONE;
      end else begin
         owner_q <= owner_d;
      end
   end

   // Next owner follows this cycle's grant; issue is never blocked by a
   // response in flight.
   always_comb begin
      owner_d = OWN_NONE;
      if (i_gnt_o) begin
         owner_d = OWN_I;
      end else if (d_gnt_o) begin
         owner_d = OWN_D;
      end
   end

   // Response qualifiers decoded from the owner.
   always_comb begin
      i_valid_o = 1'b0;
      d_valid_o = 1'b0;
      case (owner_q)
         OWN_I:   i_valid_o = 1'b1;
         OWN_D:   d_valid_o = 1'b1;
         default: ;
      endcase
   end

   // Read data is shared by both ports; consumers qualify with valid.
   assign i_rdata_o = mem_rdata_i;
   assign d_rdata_o = mem_rdata_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter with a behavioural model.
module tb_mem_port_arbiter;

   localparam int unsigned AW   = 32;
   localparam int unsigned DW   = 32;
   localparam int unsigned MAXR = 4;

   logic          clk = 1'b0;
   logic          rst_i;
   logic          i_req_i;
   logic [AW-1:0] i_addr_i;
   logic          i_gnt_o;
   logic          i_valid_o;
   logic [DW-1:0] i_rdata_o;
   logic          d_req_i;
   logic          d_we_i;
   logic [AW-1:0] d_addr_i;
   logic [DW-1:0] d_wdata_i;
   logic          d_gnt_o;
   logic          d_valid_o;
   logic [DW-1:0] d_rdata_o;
   logic          mem_en_o;
   logic          mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [DW-1:0] mem_wdata_o;
   logic [DW-1:0] mem_rdata_i;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .MAX_D_RUN  (MAXR)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .i_req_i     (i_req_i),
      .i_addr_i    (i_addr_i),
      .i_gnt_o     (i_gnt_o),
      .i_valid_o   (i_valid_o),
      .i_rdata_o   (i_rdata_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_gnt_o     (d_gnt_o),
      .d_valid_o   (d_valid_o),
      .d_rdata_o   (d_rdata_o),
      .mem_en_o    (mem_en_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_rdata_i (mem_rdata_i)
   );

   function automatic logic [DW-1:0] init_word(input int unsigned k);
      return {16'hC0DE, 16'(k * 7 + 3)};
   endfunction

   function automatic logic [7:0] widx(input logic [AW-1:0] a);
      logic [7:0] r;
      r = a[9:2];
      return r;
   endfunction

   // Environment memory: write at the access edge, read data one cycle later.
   logic          mem_init;
   logic [DW-1:0] env_mem [0:255];
   always @(posedge clk) begin
      if (mem_init) begin
         for (int k = 0; k < 256; k++) env_mem[k] <= init_word(k);
      end else if (mem_en_o) begin
         if (mem_we_o) env_mem[widx(mem_addr_o)] <= mem_wdata_o;
         else          mem_rdata_i <= env_mem[widx(mem_addr_o)];
      end
   end

   // Reference model state.
   logic [DW-1:0] ref_mem [0:255];
   int unsigned   run;
   int unsigned   last_own;   // 0 none, 1 fetch, 2 data
   logic          last_store;
   logic [DW-1:0] last_data;

   // Observed DUT values, used by stimulus and directed checks.
   logic obs_i_gnt, obs_d_gnt, obs_d_valid;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // One cycle: inputs are set at the falling edge; check just after, then
   // advance the model to what the next rising edge should commit.
   task automatic cycle();
      logic          ei, ed;
      logic [AW-1:0] ea;
      logic [DW-1:0] ewd;
      #1;
      ei = 1'b0;
      ed = 1'b0;
      if (!rst_i) begin
         if (d_req_i && (!i_req_i || run < MAXR)) ed = 1'b1;
         else if (i_req_i)                       ei = 1'b1;
      end
      ea  = ed ? d_addr_i : (ei ? i_addr_i : '0);
      ewd = ed ? d_wdata_i : '0;
      chk("i_gnt",     32'(i_gnt_o),     32'(ei));
      chk("d_gnt",     32'(d_gnt_o),     32'(ed));
      chk("mem_en",    32'(mem_en_o),    32'(ei | ed));
      chk("mem_we",    32'(mem_we_o),    32'(ed & d_we_i));
      chk("mem_addr",  mem_addr_o,       ea);
      chk("mem_wdata", mem_wdata_o,      ewd);
      chk("i_valid",   32'(i_valid_o),   32'(last_own == 1));
      chk("d_valid",   32'(d_valid_o),   32'(last_own == 2));
      if (last_own == 1) chk("i_rdata", i_rdata_o, last_data);
      if (last_own == 2 && !last_store) chk("d_rdata", d_rdata_o, last_data);
      obs_i_gnt   = i_gnt_o;
      obs_d_gnt   = d_gnt_o;
      obs_d_valid = d_valid_o;
      if (rst_i) begin
         run      = 0;
         last_own = 0;
      end else begin
         if (ei) begin
            last_own  = 1;
            last_data = ref_mem[widx(i_addr_i)];
         end else if (ed) begin
            last_own   = 2;
            last_store = d_we_i;
            last_data  = ref_mem[widx(d_addr_i)];
            if (d_we_i) ref_mem[widx(d_addr_i)] = d_wdata_i;
         end else begin
            last_own = 0;
         end
         if (!i_req_i || ei) run = 0;
         else if (ed && run < MAXR) run = run + 1;
      end
      @(negedge clk);
   endtask

   logic i_pend, d_pend;

   initial begin
      for (int k = 0; k < 256; k++) ref_mem[k] = init_word(k);
      run = 0; last_own = 0; last_store = 1'b0; last_data = '0;
      rst_i = 1'b1; mem_init = 1'b1;
      i_req_i = 1'b0; i_addr_i = '0;
      d_req_i = 1'b0; d_we_i = 1'b0; d_addr_i = '0; d_wdata_i = '0;
      @(negedge clk);
      mem_init = 1'b0;

      // Reset held with both requests pending, then first grant to data.
      i_req_i = 1'b1; i_addr_i = 32'h20;
      d_req_i = 1'b1; d_addr_i = 32'h24;
      cycle();
      cycle();
      rst_i = 1'b0;
      cycle();
      chk("post_rst_first_d", 32'(obs_d_gnt), 32'd1);
      i_req_i = 1'b0; d_req_i = 1'b0;
      cycle();

      // Fetch only, back-to-back.
      for (int k = 0; k < 3; k++) begin
         i_req_i = 1'b1; i_addr_i = 32'(k * 4);
         cycle();
         chk("fetch_only_gnt", 32'(obs_i_gnt), 32'd1);
      end
      i_req_i = 1'b0;
      cycle();
      cycle();

      // Store then load the same address.
      d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h100; d_wdata_i = 32'hDEADBEEF;
      cycle();
      d_we_i = 1'b0; d_wdata_i = '0;
      cycle();
      d_req_i = 1'b0;
      chk("raw_valid", 32'(d_valid_o), 32'd1);
      chk("raw_load",  d_rdata_o,      32'hDEADBEEF);
      cycle();

      // Fairness: continuous contention gives D,D,D,D,I.
      i_req_i = 1'b1; d_req_i = 1'b1; d_we_i = 1'b0;
      i_addr_i = 32'h40; d_addr_i = 32'h80;
      for (int k = 0; k < 15; k++) begin
         cycle();
         chk("fair_pat", 32'(obs_d_gnt), 32'((k % 5) != 4));
         if (obs_i_gnt) i_addr_i = i_addr_i + 32'd4;
         if (obs_d_gnt) d_addr_i = d_addr_i + 32'd4;
      end
      i_req_i = 1'b0; d_req_i = 1'b0;
      cycle();

      // Contention stall: fetch loses one cycle to a single load.
      i_req_i = 1'b1; i_addr_i = 32'h44;
      d_req_i = 1'b1; d_addr_i = 32'h88;
      cycle();
      chk("stall_i", 32'(obs_i_gnt), 32'd0);
      d_req_i = 1'b0;
      cycle();
      chk("stall_regnt", 32'(obs_i_gnt), 32'd1);
      i_req_i = 1'b0;
      cycle();

      // Reset right after a load grant discards the response.
      d_req_i = 1'b1; d_addr_i = 32'h8C;
      cycle();
      d_req_i = 1'b0; rst_i = 1'b1;
      cycle();
      cycle();
      chk("rst_mid_dvalid", 32'(obs_d_valid), 32'd0);
      rst_i = 1'b0;
      cycle();
      chk("rst_mid_after", 32'(obs_d_valid), 32'd0);

      // Random traffic with requesters obeying the hold-until-grant rule.
      i_pend = 1'b0; d_pend = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (!i_pend && $urandom_range(0, 3) != 0) begin
            i_pend   = 1'b1;
            i_addr_i = {22'b0, 8'($urandom_range(0, 31)), 2'b00};
         end
         if (!d_pend && $urandom_range(0, 3) != 0) begin
            d_pend    = 1'b1;
            d_we_i    = 1'($urandom_range(0, 1));
            d_addr_i  = {22'b0, 8'($urandom_range(0, 31)), 2'b00};
            d_wdata_i = $urandom;
         end
         i_req_i = i_pend;
         d_req_i = d_pend;
         rst_i   = ($urandom_range(0, 63) == 0);
         cycle();
         if (obs_i_gnt) i_pend = 1'b0;
         if (obs_d_gnt) d_pend = 1'b0;
      end
      rst_i = 1'b0; i_req_i = 1'b0; d_req_i = 1'b0;
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port main memory between the instruction-fetch port and the data (load/store) port of the pipelined core. It grants one access per cycle, returns read data one cycle after the grant, and tags each response to the correct requester. Denied requesters are stalled via their grant signals, which feed the hazard unit. A bounded-starvation counter guarantees fetch progress under back-to-back data traffic.

## Interface
- `ADDR_WIDTH`, 32: byte address width.
- `DATA_WIDTH`, 32: data word width.
- `MAX_D_RUN`, 4: maximum consecutive data grants while fetch is waiting; range 1..15.

Ports:
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  synchronous, active-high reset.
- `i_req_i`  in  1  fetch request.
- `i_addr_i`  in  ADDR_WIDTH  fetch address.
- `i_gnt_o`  out  1  fetch request accepted this cycle.
- `i_valid_o`  out  1  fetch response valid.
- `i_rdata_o`  out  DATA_WIDTH  fetch read data.
- `d_req_i`  in  1  data request.
- `d_we_i`  in  1  1 = store, 0 = load.
- `d_addr_i`  in  ADDR_WIDTH  data address.
- `d_wdata_i`  in  DATA_WIDTH  store data.
- `d_gnt_o`  out  1  data request accepted this cycle.
- `d_valid_o`  out  1  data response valid (load data or store ack).
- `d_rdata_o`  out  DATA_WIDTH  load data.
- `mem_en_o`  out  1  memory access strobe.
- `mem_we_o`  out  1  memory write enable.
- `mem_addr_o`  out  ADDR_WIDTH  memory address.
- `mem_wdata_o`  out  DATA_WIDTH  memory write data.
- `mem_rdata_i`  in  DATA_WIDTH  memory read data; valid the cycle after `mem_en_o`.

## Operation
- **Handshake:**
  - A request is accepted in the cycle where req and gnt are both high.
  - Requester holds req, addr, we and wdata stable until gnt.
  - Keeping req high after gnt issues a new request.
- **Grant rule (combinational):**
  - Only i_req: grant fetch.
  - Only d_req: grant data.
  - Both: grant data if `starve_cnt < MAX_D_RUN`, else grant fetch.
  - Never both grants; no grant while `rst_i`.
- **Memory drive:** `mem_en_o` = i_gnt | d_gnt; addr, we and wdata are muxed from the granted port. With no grant: en = we = 0, addr = wdata = 0. Fetch grants force we = 0.
- **Response FSM:** `resp_owner` register with states OWN_NONE, OWN_I, OWN_D.
  - Next state is OWN_I on i_gnt, OWN_D on d_gnt, else OWN_NONE.
  - Issue is allowed in every state, so throughput is 1 access/cycle.
- **Response outputs:**
  - i_valid_o = (resp_owner == OWN_I); d_valid_o = (resp_owner == OWN_D).
  - i_rdata_o = d_rdata_o = mem_rdata_i (pass-through); consumers qualify with valid.
  - Store response: d_valid pulses and d_rdata_o is don't-care.
- **Starvation counter:** `starve_cnt`, width $clog2(MAX_D_RUN+1).
  - Increments on d_gnt while i_req_i is high.
  - Clears on i_gnt, or when i_req_i is low.
  - Saturates at MAX_D_RUN.

## Timing
- Latency: request accepted at cycle N → valid and rdata at N+1. Store is written at the N clock edge; ack at N+1.
- Reset values: resp_owner = OWN_NONE, starve_cnt = 0. Hence i_valid_o = d_valid_o = 0 the cycle after reset, and all gnt/mem_en outputs are 0 while rst_i is high.
- Reset mid-access: the pending response is discarded and no valid is produced. The requester re-issues.
- Simultaneous response and new grant in one cycle is legal: valid for access N and gnt for access N+1 coexist.
- Read-after-write to the same address on consecutive grants returns the new data. This relies on the memory's write-then-read ordering across cycles.

## Structure
- Package `mem_arb_pkg`:
  - enum `owner_t` {OWN_NONE, OWN_I, OWN_D}.
  - default constant `MAX_D_RUN_DEF = 4`.
- Sub-module `arb_fair_cnt`: saturating starvation counter. Inputs: inc, clr, limit. Output: at_limit.
- Top level holds the grant logic, memory mux and response register.

## Test plan
- **Reset:** hold rst_i 2 cycles with both reqs high → no gnt and mem_en_o = 0 throughout. After release, first grant goes to data, and valids are 0 in the cycle after reset.
- **Fetch only:** i_req with addr 0x0, 0x4, 0x8 back-to-back → i_gnt each cycle, i_valid cycles 1–3 with the matching memory words, d_valid never high.
- **Store then load:** d_req store 0xDEADBEEF to 0x100, then load 0x100 → d_valid on both response cycles; load returns 0xDEADBEEF.
- **Fairness:** both reqs high continuously, MAX_D_RUN = 4 → grant pattern D,D,D,D,I repeating. Fetch never waits more than 4 cycles.
- **Contention stall:** single data load while fetch requests → i_gnt low exactly 1 cycle; fetch addr held, then granted next cycle.
- **Reset mid-access:** assert rst_i in the cycle after a load grant → no d_valid next cycle; resp_owner = OWN_NONE.
